// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C read-back checker and its neighbours.
// Holds error codes, checker FSM state encodings, the system clock
// frequency and the expected-byte helper.
package i2c_pkg;

  localparam int unsigned CLK_FREQ_HZ = 100000000;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned ERR_W       = 2;

  localparam logic [ERR_W-1:0] ERR_NONE     = 2'b00;
  localparam logic [ERR_W-1:0] ERR_MISMATCH = 2'b01;
  localparam logic [ERR_W-1:0] ERR_NACK     = 2'b10;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_PASS  = 2'd2,
    ST_FAIL  = 2'd3
  } state_e;

  // Expected value of byte idx: seed + idx, wrapping modulo 256.
  function automatic logic [BYTE_W-1:0] expected_byte(input logic [BYTE_W-1:0] seed,
                                                      input logic [BYTE_W-1:0] idx);
    return BYTE_W'(seed + idx);
  endfunction

endpackage

// File: rtl/timeout_timer.sv
// Loadable down-counter watchdog.
// Ports: clk, reset (async active-low), load_i/load_val_i reload the
// count, tick_i decrements it (saturating at zero), zero_c flags zero.
module timeout_timer #(
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             tick_i,
  output logic             zero_c
);

  logic [WIDTH-1:0] count_q, count_d;

  // Load wins over tick; the count never wraps below zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/i2c_result_checker.sv
// Checks the byte stream read back by the I2C master against the pattern
// SEED, SEED+1, ... and reports a sticky pass/fail result per session.
// Ports: clk, reset (async active-low); start begins/restarts a session;
// rx_valid/rx_data deliver bytes; ack_err reports a NACK.
// Outputs (registered): busy, pass, fail, err_code, byte_cnt.
module i2c_result_checker
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_BYTES      = 4,
  parameter logic [7:0]  SEED           = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       ack_err,
  output logic       busy,
  output logic       pass,
  output logic       fail,
  output logic [1:0] err_code,
  output logic [7:0] byte_cnt
);

  localparam int unsigned      TMR_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       LAST_CNT   = 8'(NUM_BYTES);

  state_e     state_q, state_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [1:0] err_q, err_d;
  logic       busy_q, busy_d;
  logic       pass_q, pass_d;
  logic       fail_q, fail_d;

  logic       tmr_load_c;
  logic       tmr_tick_c;
  logic       tmr_zero_c;
  logic [7:0] exp_byte_c;
  logic [7:0] cnt_inc_c;

  assign exp_byte_c = expected_byte(SEED, byte_cnt_q);
  assign cnt_inc_c  = byte_cnt_q + 8'd1;

  // Inter-byte watchdog; reloaded on start and on every accepted byte.
  timeout_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load_c),
    .load_val_i (TMR_RELOAD),
    .tick_i     (tmr_tick_c),
    .zero_c     (tmr_zero_c)
  );

  // Next-state and result logic; CHECK events resolved in priority order.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    err_d      = err_q;
    tmr_load_c = 1'b0;
    tmr_tick_c = 1'b0;

    case (state_q)
      ST_CHECK: begin
        if (start) begin
          byte_cnt_d = '0;
          err_d      = ERR_NONE;
          tmr_load_c = 1'b1;
        end else if (ack_err) begin
          state_d = ST_FAIL;
          err_d   = ERR_NACK;
        end else if (rx_valid && (rx_data != exp_byte_c)) begin
          state_d = ST_FAIL;
          err_d   = ERR_MISMATCH;
        end else if (rx_valid) begin
          byte_cnt_d = cnt_inc_c;
          tmr_load_c = 1'b1;
          if (cnt_inc_c == LAST_CNT) begin
            state_d = ST_PASS;
          end
        end else if (tmr_zero_c) begin
          state_d = ST_FAIL;
          err_d   = ERR_TIMEOUT;
        end else begin
          tmr_tick_c = 1'b1;
        end
      end
      default: begin
        // IDLE, PASS and FAIL only react to start.
        if (start) begin
          state_d    = ST_CHECK;
          byte_cnt_d = '0;
          err_d      = ERR_NONE;
          tmr_load_c = 1'b1;
        end
      end
    endcase

    busy_d = (state_d == ST_CHECK);
    pass_d = (state_d == ST_PASS);
    fail_d = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      err_q      <= ERR_NONE;
      busy_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
    end
  end

  assign busy     = busy_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign err_code = err_q;
  assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_i2c_result_checker.sv
// Bench for i2c_result_checker: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a deadline-based model.
// Two instances share the stimulus: A (4 bytes, seed A5), B (3 bytes, seed FE).
module tb_i2c_result_checker;

  localparam int TMO = 100;

  logic       clk, reset, start, rx_valid, ack_err;
  logic [7:0] rx_data;
  logic       busy_a, pass_a, fail_a, busy_b, pass_b, fail_b;
  logic [1:0] err_a, err_b;
  logic [7:0] cnt_a, cnt_b;

  i2c_result_checker #(.NUM_BYTES(4), .SEED(8'hA5), .TIMEOUT_CYCLES(TMO)) dut_a (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .ack_err(ack_err), .busy(busy_a), .pass(pass_a), .fail(fail_a), .err_code(err_a),
    .byte_cnt(cnt_a));

  i2c_result_checker #(.NUM_BYTES(3), .SEED(8'hFE), .TIMEOUT_CYCLES(TMO)) dut_b (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .ack_err(ack_err), .busy(busy_b), .pass(pass_b), .fail(fail_b), .err_code(err_b),
    .byte_cnt(cnt_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [12:0] pk(input bit b, input bit p, input bit f,
                                     input logic [1:0] e, input logic [7:0] c);
    return {b, p, f, e, c};
  endfunction

  wire [12:0] out_a = {busy_a, pass_a, fail_a, err_a, cnt_a};
  wire [12:0] out_b = {busy_b, pass_b, fail_b, err_b, cnt_b};

  task automatic chk(input string nm, input logic [12:0] got, input logic [12:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got busy/pass/fail/err/cnt=%0b/%0b/%0b/%0d/%0d want %0b/%0b/%0b/%0d/%0d",
               nm, got[12], got[11], got[10], got[9:8], got[7:0],
               exp[12], exp[11], exp[10], exp[9:8], exp[7:0]);
    end
  endtask

  // Behavioural model: a session is a phase plus an absolute deadline cycle.
  typedef struct {
    int     ph;   // 0 idle, 1 checking, 2 passed, 3 failed
    int     cnt;
    int     err;
    longint dl;
  } mdl_t;

  function automatic mdl_t m_step(input mdl_t m, input int nb, input int seed, input bit st,
                                  input bit rv, input int rd, input bit ak, input longint c);
    mdl_t n = m;
    if (st) begin
      n.ph = 1; n.cnt = 0; n.err = 0; n.dl = c + TMO;
    end else if (m.ph == 1) begin
      if (ak) begin
        n.ph = 3; n.err = 2;
      end else if (rv && rd != (seed + m.cnt) % 256) begin
        n.ph = 3; n.err = 1;
      end else if (rv) begin
        n.cnt = m.cnt + 1;
        n.dl  = c + TMO;
        if (n.cnt == nb) n.ph = 2;
      end else if (c >= m.dl) begin
        n.ph = 3; n.err = 3;
      end
    end
    return n;
  endfunction

  function automatic logic [12:0] m_out(input mdl_t m);
    return pk(m.ph == 1, m.ph == 2, m.ph == 3, 2'(m.err), 8'(m.cnt));
  endfunction

  longint cyc = 0;
  mdl_t   ma, mb;
  bit     rand_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ma <= '{ph: 0, cnt: 0, err: 0, dl: 0};
      mb <= '{ph: 0, cnt: 0, err: 0, dl: 0};
    end else begin
      ma <= m_step(ma, 4, 'hA5, start, rx_valid, int'(rx_data), ack_err, cyc);
      mb <= m_step(mb, 3, 'hFE, start, rx_valid, int'(rx_data), ack_err, cyc);
    end
  end

  always @(negedge clk) begin
    if (rand_on) begin
      chk("rand_a", out_a, m_out(ma));
      chk("rand_b", out_b, m_out(mb));
    end
  end

  // One-cycle input pulse, sampled by the DUT on the following edge.
  task automatic drive(input bit st, input bit rv, input logic [7:0] rd, input bit ak);
    @(posedge clk); #1;
    start = st; rx_valid = rv; rx_data = rd; ack_err = ak;
    @(posedge clk); #1;
    start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; ack_err = 1'b0;
  endtask

  typedef struct {
    bit          st;
    bit          rv;
    logic [7:0]  rd;
    bit          ak;
    int          gap;
    logic [12:0] exp;
  } vec_t;

  function automatic vec_t mk(input bit st, input bit rv, input logic [7:0] rd, input bit ak,
                              input int gap, input logic [12:0] exp);
    vec_t v;
    v.st = st; v.rv = rv; v.rd = rd; v.ak = ak; v.gap = gap; v.exp = exp;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; ack_err = 1'b0;

    // Vectors for instance A: {start, rx_valid, rx_data, ack_err, gap, expected}.
    tbl.push_back(mk(1, 0, 8'h00, 0, 0,  pk(1, 0, 0, 2'd0, 8'd0)));
    tbl.push_back(mk(0, 1, 8'hA5, 0, 49, pk(1, 0, 0, 2'd0, 8'd1)));
    tbl.push_back(mk(0, 1, 8'hA6, 0, 49, pk(1, 0, 0, 2'd0, 8'd2)));
    tbl.push_back(mk(0, 1, 8'hA7, 0, 49, pk(1, 0, 0, 2'd0, 8'd3)));
    tbl.push_back(mk(0, 1, 8'hA8, 0, 0,  pk(0, 1, 0, 2'd0, 8'd4)));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0,  pk(0, 1, 0, 2'd0, 8'd4)));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0,  pk(0, 1, 0, 2'd0, 8'd4)));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0,  pk(1, 0, 0, 2'd0, 8'd0)));
    tbl.push_back(mk(0, 1, 8'hA5, 0, 0,  pk(1, 0, 0, 2'd0, 8'd1)));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0,  pk(0, 0, 1, 2'd1, 8'd1)));
    tbl.push_back(mk(0, 1, 8'hA7, 0, 0,  pk(0, 0, 1, 2'd1, 8'd1)));
    tbl.push_back(mk(0, 0, 8'h00, 1, 0,  pk(0, 0, 1, 2'd1, 8'd1)));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0,  pk(1, 0, 0, 2'd0, 8'd0)));
    tbl.push_back(mk(0, 1, 8'hA5, 1, 0,  pk(0, 0, 1, 2'd2, 8'd0)));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0,  pk(1, 0, 0, 2'd0, 8'd0)));
    tbl.push_back(mk(0, 1, 8'hA5, 0, 0,  pk(1, 0, 0, 2'd0, 8'd1)));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0,  pk(1, 0, 0, 2'd0, 8'd0)));
    tbl.push_back(mk(0, 1, 8'hA6, 0, 0,  pk(0, 0, 1, 2'd1, 8'd0)));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0,  pk(1, 0, 0, 2'd0, 8'd0)));
    tbl.push_back(mk(0, 1, 8'hA5, 0, 0,  pk(1, 0, 0, 2'd0, 8'd1)));
    tbl.push_back(mk(1, 1, 8'hA6, 0, 0,  pk(1, 0, 0, 2'd0, 8'd0)));

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_a", out_a, pk(0, 0, 0, 2'd0, 8'd0));
    chk("reset_b", out_b, pk(0, 0, 0, 2'd0, 8'd0));
    @(posedge clk); #1 reset = 1'b1;

    // IDLE ignores bytes and NACKs.
    drive(0, 1, 8'hA5, 1);
    @(negedge clk);
    chk("idle_ignore", out_a, pk(0, 0, 0, 2'd0, 8'd0));

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].rv, tbl[i].rd, tbl[i].ak);
      repeat (tbl[i].gap) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d", i), out_a, tbl[i].exp);
    end

    // Timeout: byte driven after edge P, accepted at P+1, fail at P+1+TMO.
    drive(1, 0, 8'h00, 0);
    drive(0, 1, 8'hA5, 0);
    repeat (TMO - 1) @(posedge clk);
    @(negedge clk);
    chk("tmo_before", out_a, pk(1, 0, 0, 2'd0, 8'd1));
    @(posedge clk);
    @(negedge clk);
    chk("tmo_fire", out_a, pk(0, 0, 1, 2'd3, 8'd1));

    // Seed wrap FE, FF, 00 with a restart in the middle (instance B).
    drive(1, 0, 8'h00, 0);
    drive(0, 1, 8'hFE, 0);
    drive(0, 1, 8'hFF, 0);
    @(negedge clk);
    chk("wrap_two", out_b, pk(1, 0, 0, 2'd0, 8'd2));
    drive(1, 0, 8'h00, 0);
    @(negedge clk);
    chk("wrap_restart", out_b, pk(1, 0, 0, 2'd0, 8'd0));
    drive(0, 1, 8'hFE, 0);
    drive(0, 1, 8'hFF, 0);
    drive(0, 1, 8'h00, 0);
    @(negedge clk);
    chk("wrap_pass", out_b, pk(0, 1, 0, 2'd0, 8'd3));
    chk("wrap_a_mis", out_a, pk(0, 0, 1, 2'd1, 8'd0));

    // Asynchronous reset in the middle of a session.
    drive(1, 0, 8'h00, 0);
    drive(0, 1, 8'hA5, 0);
    drive(0, 1, 8'hA6, 0);
    @(negedge clk);
    chk("rst_pre", out_a, pk(1, 0, 0, 2'd0, 8'd2));
    @(posedge clk); #2 reset = 1'b0;
    #1;
    chk("rst_async_a", out_a, pk(0, 0, 0, 2'd0, 8'd0));
    chk("rst_async_b", out_b, pk(0, 0, 0, 2'd0, 8'd0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    drive(1, 0, 8'h00, 0);
    drive(0, 1, 8'hA5, 0);
    @(negedge clk);
    chk("rst_fresh", out_a, pk(1, 0, 0, 2'd0, 8'd1));

    // Random traffic checked every cycle against the model.
    rand_on = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      reset    = ($urandom_range(0, 599) != 0);
      start    = ($urandom_range(0, 59) == 0);
      ack_err  = ($urandom_range(0, 149) == 0);
      rx_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0)
        rx_data = 8'($urandom);
      else if ($urandom_range(0, 1) == 1)
        rx_data = 8'((8'hA5 + ma.cnt) % 256);
      else
        rx_data = 8'((8'hFE + mb.cnt) % 256);
      if ($urandom_range(0, 299) == 0) begin
        start = 1'b0; ack_err = 1'b0; rx_valid = 1'b0;
        repeat (TMO + 10) @(posedge clk);
      end
    end
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; ack_err = 1'b0; rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rand_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
